// File: rtl/pipe_pkg.sv
// Shared definitions for the writeback-stage pipeline registers.
// Default widths and the packed writeback payload layout.
package pipe_pkg;
   localparam int XLEN_DEF = 64;
   localparam int RA_W_DEF = 5;

   typedef struct packed {
      logic [RA_W_DEF-1:0] rd;
      logic [XLEN_DEF-1:0] r;
      logic [XLEN_DEF-1:0] d;
      logic                m2reg;
      logic                wreg;
   } wb_payload_t;

   function automatic int wb_payload_w(input int xlen, input int ra_w);
      return ra_w + 2 * xlen + 2;
   endfunction
endpackage

// File: rtl/skid_buffer.sv
// Generic valid/ready register slice: a 2-entry skid buffer (registered in_ready)
// or a single entry with combinational in_ready, selected by SKID.
module skid_buffer #(
   parameter int PAYLOAD_W = 8,
   parameter bit SKID      = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data
);
   logic                 main_valid;
   logic [PAYLOAD_W-1:0] main_data;
   logic                 accept;
   logic                 drain;

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign accept    = in_valid & in_ready;
   assign drain     = main_valid & out_ready;

   generate
      if (SKID) begin : g_skid
         logic                 skid_valid;
         logic [PAYLOAD_W-1:0] skid_data;

         // in_ready comes straight from a flop; rst masks it so no beat is accepted in reset
         assign in_ready = !skid_valid && !rst;

         always_ff @(posedge clk) begin
            if (rst) begin
               main_valid <= 1'b0;
               skid_valid <= 1'b0;
               main_data  <= '0;
               skid_data  <= '0;
            end else if (flush) begin
               main_valid <= 1'b0;
               skid_valid <= 1'b0;
            end else if (skid_valid) begin
               if (drain) begin
                  main_data  <= skid_data;
                  skid_valid <= 1'b0;
               end
            end else if (accept) begin
               if (!main_valid || out_ready) begin
                  main_data  <= in_data;
                  main_valid <= 1'b1;
               end else begin
                  skid_data  <= in_data;
                  skid_valid <= 1'b1;
               end
            end else if (drain) begin
               main_valid <= 1'b0;
            end
         end
      end else begin : g_single
         assign in_ready = (!main_valid || out_ready) && !rst;

         always_ff @(posedge clk) begin
            if (rst) begin
               main_valid <= 1'b0;
               main_data  <= '0;
            end else if (flush) begin
               main_valid <= 1'b0;
            end else if (accept) begin
               main_data  <= in_data;
               main_valid <= 1'b1;
            end else if (drain) begin
               main_valid <= 1'b0;
            end
         end
      end
   endgenerate
endmodule

// File: rtl/pipe_reg_wb_skid.sv
// MEM/WB pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and suppression of writes to x0.
module pipe_reg_wb_skid
   import pipe_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int RA_W = RA_W_DEF,
   parameter bit SKID = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [RA_W-1:0] in_rd,
   input  logic [XLEN-1:0] in_r,
   input  logic [XLEN-1:0] in_d,
   input  logic            in_m2reg,
   input  logic            in_wreg,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [RA_W-1:0] out_rd,
   output logic [XLEN-1:0] out_r,
   output logic [XLEN-1:0] out_d,
   output logic            out_m2reg,
   output logic            out_wreg
);
   localparam int PAYLOAD_W = wb_payload_w(XLEN, RA_W);

   typedef struct packed {
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] r;
      logic [XLEN-1:0] d;
      logic            m2reg;
      logic            wreg;
   } payload_t;

   payload_t pay_in;
   payload_t pay_out;
   logic     held_valid;

   // x0 is hard-wired zero, so its write request is dropped at capture
   always_comb begin
      pay_in       = '0;
      pay_in.rd    = in_rd;
      pay_in.r     = in_r;
      pay_in.d     = in_d;
      pay_in.m2reg = in_m2reg;
      pay_in.wreg  = in_wreg & (in_rd != '0);
   end

   skid_buffer #(
      .PAYLOAD_W(PAYLOAD_W),
      .SKID     (SKID)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (pay_in),
      .out_valid(held_valid),
      .out_ready(out_ready),
      .out_data (pay_out)
   );

   assign out_valid = held_valid;
   assign out_rd    = pay_out.rd;
   assign out_r     = pay_out.r;
   assign out_d     = pay_out.d;
   assign out_m2reg = pay_out.m2reg;
   assign out_wreg  = pay_out.wreg & held_valid;
endmodule

// File: tb/tb_pipe_reg_wb_skid.sv
// Bench for pipe_reg_wb_skid: SKID=1 and SKID=0 instances driven in parallel,
// each compared cycle by cycle against a queue-based reference.
module tb_pipe_reg_wb_skid;
   import pipe_pkg::*;

   localparam int XLEN = 64;
   localparam int RA_W = 5;

   logic            clk = 1'b0;
   logic            rst, flush, in_valid, out_ready, in_m2reg, in_wreg;
   logic [RA_W-1:0] in_rd;
   logic [XLEN-1:0] in_r, in_d;

   logic            ir1, ov1, om1, ow1;
   logic [RA_W-1:0] ord1;
   logic [XLEN-1:0] or1, od1;
   logic            ir0, ov0, om0, ow0;
   logic [RA_W-1:0] ord0;
   logic [XLEN-1:0] or0, od0;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] r;
      logic [XLEN-1:0] d;
      logic            m2reg;
      logic            wreg;
   } ent_t;

   ent_t q1[$];
   ent_t q0[$];

   always #5 clk = ~clk;

   pipe_reg_wb_skid #(.XLEN(XLEN), .RA_W(RA_W), .SKID(1'b1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
      .in_rd(in_rd), .in_r(in_r), .in_d(in_d), .in_m2reg(in_m2reg), .in_wreg(in_wreg),
      .out_valid(ov1), .out_ready(out_ready), .out_rd(ord1), .out_r(or1), .out_d(od1),
      .out_m2reg(om1), .out_wreg(ow1));

   pipe_reg_wb_skid #(.XLEN(XLEN), .RA_W(RA_W), .SKID(1'b0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
      .in_rd(in_rd), .in_r(in_r), .in_d(in_d), .in_m2reg(in_m2reg), .in_wreg(in_wreg),
      .out_valid(ov0), .out_ready(out_ready), .out_rd(ord0), .out_r(or0), .out_d(od0),
      .out_m2reg(om0), .out_wreg(ow0));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check against the queues, then advance them at posedge.
   task automatic cyc(input logic r_i, input logic f_i, input logic iv, input logic ordy,
                      input logic [RA_W-1:0] rd, input logic [XLEN-1:0] r,
                      input logic [XLEN-1:0] d, input logic m2, input logic wr);
      logic e_ir1, e_ir0, acc1, acc0, drn1, drn0;
      ent_t e;
      @(negedge clk);
      rst = r_i; flush = f_i; in_valid = iv; out_ready = ordy;
      in_rd = rd; in_r = r; in_d = d; in_m2reg = m2; in_wreg = wr;
      #1;
      e_ir1 = !r_i && (q1.size() < 2);
      e_ir0 = !r_i && (q0.size() == 0 || ordy);
      chk("in_ready_s1", 64'(ir1), 64'(e_ir1));
      chk("in_ready_s0", 64'(ir0), 64'(e_ir0));
      chk("out_valid_s1", 64'(ov1), 64'(q1.size() != 0));
      chk("out_valid_s0", 64'(ov0), 64'(q0.size() != 0));
      if (q1.size() != 0) begin
         chk("rd_s1", 64'(ord1), 64'(q1[0].rd));
         chk("r_s1", or1, q1[0].r);
         chk("d_s1", od1, q1[0].d);
         chk("m2reg_s1", 64'(om1), 64'(q1[0].m2reg));
         chk("wreg_s1", 64'(ow1), 64'(q1[0].wreg));
      end else chk("wreg_idle_s1", 64'(ow1), 64'd0);
      if (q0.size() != 0) begin
         chk("rd_s0", 64'(ord0), 64'(q0[0].rd));
         chk("r_s0", or0, q0[0].r);
         chk("d_s0", od0, q0[0].d);
         chk("m2reg_s0", 64'(om0), 64'(q0[0].m2reg));
         chk("wreg_s0", 64'(ow0), 64'(q0[0].wreg));
      end else chk("wreg_idle_s0", 64'(ow0), 64'd0);
      acc1 = iv && e_ir1;
      acc0 = iv && e_ir0;
      drn1 = (q1.size() != 0) && ordy;
      drn0 = (q0.size() != 0) && ordy;
      e.rd = rd; e.r = r; e.d = d; e.m2reg = m2; e.wreg = wr && (rd != 0);
      @(posedge clk);
      if (r_i || f_i) begin
         q1.delete();
         q0.delete();
      end else begin
         if (drn1) void'(q1.pop_front());
         if (drn0) void'(q0.pop_front());
         if (acc1) q1.push_back(e);
         if (acc0) q0.push_back(e);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      in_rd = 5'd1; in_r = 64'h1; in_d = 64'h2; in_m2reg = 1'b1; in_wreg = 1'b1;
      @(posedge clk);
      // Reset held with in_valid high
      cyc(1, 0, 1, 0, 5'd1, 64'h1, 64'h2, 1, 1);
      cyc(1, 0, 1, 0, 5'd1, 64'h1, 64'h2, 1, 1);
      #1;
      chk("rst_rd", 64'(ord1), 64'd0);
      chk("rst_r", or1, 64'd0);
      chk("rst_d", od1, 64'd0);
      chk("rst_m2reg", 64'(om1), 64'd0);
      chk("rst_r_s0", or0, 64'd0);
      // Streaming
      cyc(0, 0, 1, 1, 5'd3, 64'h11, 64'h0, 0, 1);
      cyc(0, 0, 1, 1, 5'd4, 64'h22, 64'h0, 0, 1);
      cyc(0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 0, 0);
      cyc(0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 0, 0);
      // Backpressure: A then B, then release
      cyc(0, 0, 1, 0, 5'd5, 64'hAA, 64'h1, 1, 1);
      cyc(0, 0, 1, 0, 5'd6, 64'hBB, 64'h2, 0, 1);
      cyc(0, 0, 1, 0, 5'd8, 64'hCC, 64'h3, 0, 1);
      cyc(0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 0, 0);
      cyc(0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 0, 0);
      cyc(0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 0, 0);
      // x0 suppression
      cyc(0, 0, 1, 0, 5'd0, 64'hDEAD, 64'h0, 0, 1);
      cyc(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0);
      chk("x0_wreg", 64'(ow1), 64'd0);
      chk("x0_valid", 64'(ov1), 64'd1);
      cyc(0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 0, 0);
      // Flush with main and skid full and a new beat offered
      cyc(0, 0, 1, 0, 5'd10, 64'h100, 64'h0, 0, 1);
      cyc(0, 0, 1, 0, 5'd11, 64'h101, 64'h0, 0, 1);
      cyc(0, 1, 1, 0, 5'd7, 64'h777, 64'h0, 0, 1);
      cyc(0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 0, 0);
      // SKID=0: full and stalled, then release with a same-cycle accept
      cyc(0, 0, 1, 0, 5'd12, 64'h120, 64'h0, 0, 1);
      cyc(0, 0, 1, 0, 5'd13, 64'h130, 64'h0, 0, 1);
      cyc(0, 0, 1, 1, 5'd9, 64'h99, 64'h9, 1, 1);
      cyc(0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 0, 0);
      cyc(0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 0, 0);
      // Randomized traffic, including rst, flush and writes to x0
      for (int i = 0; i < 600; i++) begin
         logic [RA_W-1:0] rd_r;
         rd_r = ($urandom_range(0, 5) == 0) ? '0 : RA_W'($urandom);
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
             1'($urandom), ($urandom_range(0, 3) != 0), rd_r,
             {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
